// File: rtl/serial_subtractor8_pkg.sv
// Shared constants, state encoding and result payload for the serial 8-bit subtractor.
//   WIDTH      : operand width
//   DIGIT_W    : bits processed per clock
//   NUM_DIGITS : digits per operation
//   CNT_W      : width of the digit counter
package serial_subtractor8_pkg;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned DIGIT_W    = 2;
  localparam int unsigned NUM_DIGITS = WIDTH / DIGIT_W;
  localparam int unsigned CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Completed result as presented on the output ports.
  typedef struct packed {
    logic [WIDTH-1:0] d;
    logic             b8;
    logic             v;
  } result_t;

  // Two's-complement overflow of a subtraction from the operand and result sign bits.
  function automatic logic signed_ovf(input logic xm, input logic ym, input logic dm);
    return (xm ^ ym) & (dm ^ xm);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit borrows.
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when y exceeds x, or when they are equal and a borrow is pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor8.sv
// Digit-serial 8-bit subtractor: computes x - y - b0 two bits per clock, LSB first.
//   clk, rst_n : clock, asynchronous active-low reset
//   x, y, b0   : minuend, subtrahend, borrow-in (sampled when start is accepted in IDLE)
//   start      : operation request, level-sampled
//   d, b8, v   : registered difference, borrow-out, signed overflow (hold until next completion)
//   busy       : high while the operation is running
//   done       : one-cycle completion pulse
module serial_subtractor8
  import serial_subtractor8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             b0,
  input  logic             start,
  output logic [WIDTH-1:0] d,
  output logic             b8,
  output logic             v,
  output logic             busy,
  output logic             done
);

  state_t                   state_q, state_nxt;
  logic                     latch_c, step_c, finish_c;

  logic [CNT_W-1:0]         cnt_q;
  logic [WIDTH-1:0]         xr_q, yr_q;
  logic                     br_q;
  logic [WIDTH-DIGIT_W-1:0] dacc_q;
  result_t                  res_q;
  logic                     busy_q, done_q;

  logic [DIGIT_W-1:0]       dig_d;
  logic                     b_mid, b_out;

  // Two chained full subtractors form the current 2-bit digit slice.
  full_subtractor u_fs0 (
    .x    (xr_q[0]),
    .y    (yr_q[0]),
    .bin  (br_q),
    .d    (dig_d[0]),
    .bout (b_mid)
  );

  full_subtractor u_fs1 (
    .x    (xr_q[1]),
    .y    (yr_q[1]),
    .bin  (b_mid),
    .d    (dig_d[1]),
    .bout (b_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state_q;
    latch_c   = 1'b0;
    step_c    = 1'b0;
    finish_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          latch_c   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
          finish_c  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: operands shift right one digit per RUN cycle,
  // difference digits enter the accumulator from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      xr_q   <= '0;
      yr_q   <= '0;
      br_q   <= 1'b0;
      dacc_q <= '0;
    end else if (latch_c) begin
      cnt_q  <= '0;
      xr_q   <= x;
      yr_q   <= y;
      br_q   <= b0;
      dacc_q <= '0;
    end else if (step_c) begin
      cnt_q  <= cnt_q + CNT_W'(1);
      xr_q   <= {DIGIT_W'(0), xr_q[WIDTH-1:DIGIT_W]};
      yr_q   <= {DIGIT_W'(0), yr_q[WIDTH-1:DIGIT_W]};
      br_q   <= b_out;
      dacc_q <= {dig_d, dacc_q[WIDTH-DIGIT_W-1:DIGIT_W]};
    end
  end

  // Result registers load together on the last digit; at that point the
  // operand registers hold the original bit 7 in position 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (finish_c) begin
      res_q.d  <= {dig_d, dacc_q};
      res_q.b8 <= b_out;
      res_q.v  <= signed_ovf(xr_q[1], yr_q[1], dig_d[1]);
    end
  end

  // Status flags registered from the next state so they track the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
    end
  end

  assign d    = res_q.d;
  assign b8   = res_q.b8;
  assign v    = res_q.v;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_serial_subtractor8.sv
// Self-checking bench for serial_subtractor8: arithmetic/latency reference model
// compared every cycle, plus directed vectors with literal expected results.
module tb_serial_subtractor8;

  logic       clk;
  logic       rst_n;
  logic [7:0] x, y;
  logic       b0;
  logic       start;
  logic [7:0] d;
  logic       b8, v, busy, done;

  int n_pass  = 0;
  int n_total = 0;

  serial_subtractor8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .y     (y),
    .b0    (b0),
    .start (start),
    .d     (d),
    .b8    (b8),
    .v     (v),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1..4 running, 5 result cycle.
  int         m_phase;
  logic [7:0] lx, ly;
  logic       lb;
  logic [7:0] m_d;
  logic       m_b8, m_v;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      lx <= 8'h00; ly <= 8'h00; lb <= 1'b0;
      m_d <= 8'h00; m_b8 <= 1'b0; m_v <= 1'b0;
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          lx <= x; ly <= y; lb <= b0;
          m_phase <= 1;
        end
      end else if (m_phase < 4) begin
        m_phase <= m_phase + 1;
      end else if (m_phase == 4) begin
        m_d  <= 8'((int'(lx) - int'(ly) - int'(lb)) & 255);
        m_b8 <= (int'(lx) < int'(ly) + int'(lb));
        m_v  <= (lx[7] != ly[7]) &&
                (8'((int'(lx) - int'(ly) - int'(lb)) & 255) >= 8'h80) != lx[7];
        m_phase <= 5;
      end else begin
        m_phase <= 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("busy", 32'(busy), 32'(m_phase >= 1 && m_phase <= 4));
    check("done", 32'(done), 32'(m_phase == 5));
    check("d",    32'(d),    32'(m_d));
    check("b8",   32'(b8),   32'(m_b8));
    check("v",    32'(v),    32'(m_v));
    check("busy_done_excl", 32'(busy & done), 32'(0));
  end

  // Drop start and wait (bounded) for done, then check the literal result.
  task automatic wait_result(input string tag, input logic [7:0] ed, input logic eb,
                             input logic ev);
    int nb;
    bit got;
    @(negedge clk);
    start = 1'b0;
    x  = 8'($urandom);
    y  = 8'($urandom);
    b0 = 1'($urandom);
    nb  = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy) nb++;
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(got), 32'(1));
    check({tag, "_d"},  32'(d),  32'(ed));
    check({tag, "_b8"}, 32'(b8), 32'(eb));
    check({tag, "_v"},  32'(v),  32'(ev));
    check({tag, "_busy_cycles"}, 32'(nb), 32'(4));
  endtask

  task automatic run_op(input string tag, input logic [7:0] ox, input logic [7:0] oy,
                        input logic ob, input logic [7:0] ed, input logic eb, input logic ev);
    @(negedge clk);
    x = ox; y = oy; b0 = ob; start = 1'b1;
    wait_result(tag, ed, eb, ev);
  endtask

  initial begin
    bit got;
    rst_n = 1'b0; start = 1'b0; x = 8'h00; y = 8'h00; b0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_d", 32'(d), 32'(0));
    check("rst_flags", 32'({b8, v, busy, done}), 32'(0));
    rst_n = 1'b1;

    run_op("basic",    8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    run_op("underflow",8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    run_op("ovf_neg",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ovf_pos",  8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("borrow_in",8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
    run_op("all_ones", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("zeros",    8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    run_op("mixed",    8'hA5, 8'h3C, 1'b1, 8'h68, 1'b0, 1'b1);

    // start held high while operands change mid-operation
    @(negedge clk);
    x = 8'h50; y = 8'h20; b0 = 1'b0; start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        x = 8'($urandom);
        y = 8'($urandom);
      end
    end
    check("held_done_seen", 32'(got), 32'(1));
    check("held_d", 32'(d), 32'(8'h30));
    @(negedge clk);
    check("held_idle_after_done", 32'(busy), 32'(0));
    @(negedge clk);
    check("held_reaccept", 32'(busy), 32'(1));
    start = 1'b0;
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    check("held_second_done", 32'(done), 32'(1));

    // reset in the 2nd RUN cycle aborts with no completion
    run_op("pre_reset", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    @(negedge clk);
    x = 8'h33; y = 8'h11; b0 = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_d", 32'(d), 32'(0));
    check("abort_flags", 32'({b8, v, busy, done}), 32'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    x = 8'h80; y = 8'h01; b0 = 1'b0; start = 1'b1;
    wait_result("after_reset", 8'h7F, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/serial_subtractor8.md
SERIAL_SUBTRACTOR8 -- requirements
Module: serial_subtractor8

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port X, input, 8 bits: minuend, sampled only at an accepted START.
REQ-004 The block SHALL have port Y, input, 8 bits: subtrahend, sampled only at an accepted START.
REQ-005 The block SHALL have port B0, input, 1 bit: borrow-in, sampled only at an accepted START.
REQ-006 The block SHALL have port START, input, 1 bit: operation request, level-sampled each edge.
REQ-007 The block SHALL have port D, output, 8 bits: registered difference X - Y - B0 (mod 256).
REQ-008 The block SHALL have port B8, output, 1 bit: registered borrow-out, 1 when X < Y + B0 (unsigned).
REQ-009 The block SHALL have port V, output, 1 bit: registered signed overflow, (X[7] != Y[7]) & (D[7] != X[7]).
REQ-010 The block SHALL have port BUSY, output, 1 bit: high while state is RUN.
REQ-011 The block SHALL have port DONE, output, 1 bit: one-cycle completion pulse, high while state is DONE.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE.
REQ-013 In IDLE, an edge with START=1 SHALL latch X, Y and B0 into working registers, clear the 2-bit digit counter and enter RUN; START=0 SHALL leave it in IDLE.
REQ-014 In RUN, each edge SHALL process one 2-bit digit, LSB first: digit k = bits [2k+1:2k], borrow chained through two full subtractors, borrow register updated, counter incremented.
REQ-015 After the edge that processes digit 3 (the 4th RUN edge), the block SHALL load D, B8 and V atomically and enter DONE.
REQ-016 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-017 Latency SHALL be fixed: START is accepted at edge t0, and DONE=1 in the cycle following edge t4.
REQ-018 START SHALL be ignored in RUN and DONE, with no effect on latched operands or the counter; it SHALL be accepted again in IDLE only.
REQ-019 D, B8 and V SHALL hold the last completed result until the next completion, and SHALL NOT change during RUN.
REQ-020 BUSY SHALL equal (state == RUN), and DONE SHALL equal (state == DONE); the two SHALL never be high together.
REQ-021 Arithmetic SHALL be 8-bit modulo: the borrow out of bit 7 is B8, and no wider intermediate is exposed.

Reset
REQ-022 When RST_N=0, the block SHALL immediately, without waiting for a clock edge, force state IDLE, counter 0, working registers 0, D=0x00, B8=0, V=0, BUSY=0 and DONE=0.
REQ-023 A reset asserted mid-RUN SHALL abort the operation, produce no DONE pulse, and leave the result outputs at 0.
REQ-024 On the first edge after RST_N rises, START SHALL be honoured as in IDLE.

Structure
REQ-025 The shared package SHALL hold WIDTH=8, DIGIT_W=2, NUM_DIGITS=4 and the state encoding constants IDLE/RUN/DONE.
REQ-026 One sub-module SHALL be used: full_subtractor (inputs X, Y, Bin; outputs D, Bout), instantiated twice for the 2-bit digit slice.
REQ-027 The FSM, counter, working shift registers and result registers SHALL reside in serial_subtractor8.

Verification
REQ-028 Basic case: X=0x50, Y=0x20, B0=0, START pulsed -> DONE at t4+1 with D=0x30, B8=0, V=0; BUSY high for exactly 4 cycles.
REQ-029 Unsigned underflow: X=0x00, Y=0x01, B0=0 -> D=0xFF, B8=1, V=0.
REQ-030 Signed overflow: X=0x80, Y=0x01 -> D=0x7F, B8=0, V=1; and X=0x7F, Y=0xFF -> D=0x80, B8=1, V=1.
REQ-031 Borrow-in: X=0x10, Y=0x0F, B0=1 -> D=0x00, B8=0, V=0.
REQ-032 START held high through RUN with X/Y changed mid-operation -> result reflects the originally latched operands; next accept occurs only from IDLE.
REQ-033 RST_N driven low at the 2nd RUN cycle -> outputs 0 immediately, no DONE pulse; a new START after release completes normally.
